vector_matrix_seq: RTL
======================

VECTOR_MATRIX_SEQ -- requirements
Module: vector_matrix_seq

Interface
REQ-001 SHALL have parameter N, default 4: length of vector A and number of rows of matrix B.
REQ-002 SHALL have parameter M, default 4: number of columns of B and number of parallel multiply lanes.
REQ-003 SHALL have parameter BW, default 16: signed width of each A and B element.
REQ-004 SHALL have parameter BW_OUT, default 32: signed width of each result element.
REQ-005 SHALL have parameter ACC_BW, default 40: signed internal accumulator width, required >= BW_OUT and >= 2*BW.
REQ-006 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port in_valid, input, 1: operands and mode are valid.
REQ-009 SHALL have port in_ready, output, 1: block accepts a new operation.
REQ-010 SHALL have port in_accum, input, 1: 1 = continue accumulating from the previous internal sums; 0 = clear first.
REQ-011 SHALL have port vectorA_bus, input, N*BW: signed, MSB-first, so A0 is in the top bits.
REQ-012 SHALL have port vectorB_bus, input, N*M*BW: signed, row-major and MSB-first, so row 0 is in the top bits and each row holds B[k][0..M-1] MSB-first.
REQ-013 SHALL have port result_bus, output, M*BW_OUT: signed, MSB-first, so R0 is in the top bits.
REQ-014 SHALL have port out_valid, output, 1: result_bus and sat are valid.
REQ-015 SHALL have port out_ready, input, 1: the consumer accepts the result.
REQ-016 SHALL have port sat, output, 1: at least one result lane was clipped.

Function
REQ-017 SHALL compute R[j] = sum over k of A[k]*B[k][j] for j = 0..M-1, optionally added to the prior accumulator contents.
REQ-018 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-019 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-020 SHALL, on an accept (in_valid & in_ready at a rising edge): register A, B and in_accum; clear the row counter; clear all M accumulators if in_accum=0, otherwise keep them; go to RUN.
REQ-021 SHALL, in RUN, add the row-counter row to each lane once per cycle: acc[j] += A[row]*B[row][j], with the full 2*BW product sign-extended to ACC_BW.
REQ-022 SHALL increment the row counter each RUN cycle and go to DONE after the edge that processes row N-1.
REQ-023 SHALL assert out_valid exactly N cycles after the accept edge, including N=1.
REQ-024 SHALL drive result lane j, in DONE, as acc[j] saturated to the signed BW_OUT range, clipping to +2^(BW_OUT-1)-1 and -2^(BW_OUT-1).
REQ-025 SHALL drive sat=1 in DONE iff any lane was clipped, and sat=0 outside DONE.
REQ-026 SHALL hold result_bus and sat stable while out_valid=1 and out_ready=0.
REQ-027 SHALL return to IDLE on out_valid & out_ready, with in_ready=1 the following cycle, so operations never overlap.
REQ-028 SHALL ignore in_valid, in_accum and operand changes while in RUN or DONE; the registered copies are used.
REQ-029 SHALL leave accumulator overflow beyond ACC_BW undefined; ACC_BW >= 2*BW+clog2(N) guarantees no wrap within one operation.
REQ-030 SHALL drive result_bus=0 whenever out_valid=0.

Reset
REQ-031 SHALL, on rst=1 at any time including mid-RUN or mid-DONE, immediately force: state IDLE; in_ready=1; out_valid=0; sat=0; result_bus=0; all accumulators, the row counter and the operand registers to 0.
REQ-032 SHALL make an in_accum=1 operation issued after reset accumulate from zero.

Verification (N=4, M=4, BW=16, BW_OUT=32, ACC_BW=40)
REQ-033 SHALL cover the basic case: A=[1,2,3,4], B row k=[k+1,0,-1,2], in_accum=0 -> out_valid 4 cycles after accept, result [30,0,-10,20], sat=0.
REQ-034 SHALL cover the accumulate case: repeat REQ-033 immediately with in_accum=1 -> result [60,0,-20,40].
REQ-035 SHALL cover saturation: A all 32767 with B all 32767 -> every lane 2147483647, sat=1; A all 32767 with B all -32768 -> every lane -2147483648, sat=1.
REQ-036 SHALL cover backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and operands -> result_bus and sat unchanged, in_ready=0, no second accept; out_ready=1 -> in_ready=1 next cycle.
REQ-037 SHALL cover reset mid-RUN: assert rst while the row counter is 2 -> all outputs as in REQ-031 without waiting for a clock; then the REQ-033 stimulus with in_accum=1 -> [30,0,-10,20].
REQ-038 SHALL cover N=1 (M=4): A=[-3], B=[1,-1,0,5] -> out_valid 1 cycle after accept, result [-3,3,0,-15].

Source files
------------

// File: rtl/vector_matrix_seq_if.sv
// Handshake and operand/result bundle for vector_matrix_seq.
// The producer/consumer side uses the master modport, the engine uses slave.
interface vector_matrix_seq_if #(
    parameter int N      = 4,
    parameter int M      = 4,
    parameter int BW     = 16,
    parameter int BW_OUT = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_accum;
    logic [N*BW-1:0]       vectorA_bus;
    logic [N*M*BW-1:0]     vectorB_bus;
    logic [M*BW_OUT-1:0]   result_bus;
    logic                  out_valid;
    logic                  out_ready;
    logic                  sat;

    modport master (
        output in_valid, in_accum, vectorA_bus, vectorB_bus, out_ready,
        input  in_ready, result_bus, out_valid, sat
    );

    modport slave (
        input  in_valid, in_accum, vectorA_bus, vectorB_bus, out_ready,
        output in_ready, result_bus, out_valid, sat
    );
endinterface

// File: rtl/vector_matrix_seq.sv
// Sequential vector x matrix multiplier: one row of B per cycle across M
// parallel lanes, optional accumulation across operations, saturated output.
module vector_matrix_seq #(
    parameter int N      = 4,
    parameter int M      = 4,
    parameter int BW     = 16,
    parameter int BW_OUT = 32,
    parameter int ACC_BW = 40
) (
    input  logic                  clk,
    input  logic                  rst,
    vector_matrix_seq_if.slave    bus
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = 2 * BW;

    // Saturation bounds expressed at accumulator width.
    localparam logic signed [ACC_BW-1:0] SAT_MAX = {{(ACC_BW-BW_OUT+1){1'b0}}, {(BW_OUT-1){1'b1}}};
    localparam logic signed [ACC_BW-1:0] SAT_MIN = {{(ACC_BW-BW_OUT+1){1'b1}}, {(BW_OUT-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                    state_r;
    state_t                    state_next_s;
    logic [N*BW-1:0]           a_r;
    logic [N*M*BW-1:0]         b_r;
    logic [CW-1:0]             row_r;
    logic signed [ACC_BW-1:0]  acc_r      [M];
    logic signed [ACC_BW-1:0]  acc_next_s [M];
    logic signed [PW-1:0]      prod_s     [M];
    logic signed [BW-1:0]      a_row_s;
    logic signed [BW-1:0]      b_row_s    [M];
    logic [M*BW_OUT-1:0]       result_r;
    logic [M*BW_OUT-1:0]       result_next_s;
    logic                      sat_r;
    logic                      sat_next_s;
    logic                      out_valid_r;
    logic                      in_ready_r;
    logic                      last_row_s;

    // Returns {clipped, value} with value clamped to the signed BW_OUT range.
    function automatic logic [BW_OUT:0] saturate(input logic signed [ACC_BW-1:0] v);
        logic [BW_OUT:0] r;
        if (v > SAT_MAX) begin
            r = {1'b1, SAT_MAX[BW_OUT-1:0]};
        end else if (v < SAT_MIN) begin
            r = {1'b1, SAT_MIN[BW_OUT-1:0]};
        end else begin
            r = {1'b0, v[BW_OUT-1:0]};
        end
        return r;
    endfunction

    assign last_row_s     = (row_r == CW'(N - 1));
    assign bus.in_ready   = in_ready_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.result_bus = result_r;
    assign bus.sat        = sat_r;

    // Select the current row of A and B from the registered operands.
    always_comb begin
        a_row_s = '0;
        for (int j = 0; j < M; j++) begin
            b_row_s[j] = '0;
        end
        for (int k = 0; k < N; k++) begin
            if (row_r == CW'(k)) begin
                a_row_s = a_r[(N-1-k)*BW +: BW];
                for (int j = 0; j < M; j++) begin
                    b_row_s[j] = b_r[((N-1-k)*M + (M-1-j))*BW +: BW];
                end
            end else begin
                a_row_s = a_row_s;
            end
        end
    end

    // Per-lane multiply-accumulate and the saturated result it would produce.
    always_comb begin
        result_next_s = '0;
        sat_next_s    = 1'b0;
        for (int j = 0; j < M; j++) begin
            logic [BW_OUT:0] s;
            prod_s[j]     = PW'(a_row_s) * PW'(b_row_s[j]);
            acc_next_s[j] = acc_r[j] + ACC_BW'(prod_s[j]);
            s             = saturate(acc_next_s[j]);
            result_next_s[(M-1-j)*BW_OUT +: BW_OUT] = s[BW_OUT-1:0];
            sat_next_s    = sat_next_s | s[BW_OUT];
        end
    end

    // Next-state logic for the operation sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.in_valid) state_next_s = RUN;
                else              state_next_s = IDLE;
            end
            RUN: begin
                if (last_row_s) state_next_s = DONE;
                else            state_next_s = RUN;
            end
            DONE: begin
                if (bus.out_ready) state_next_s = IDLE;
                else               state_next_s = DONE;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= IDLE;
        else     state_r <= state_next_s;
    end

    // Operand capture, accumulation and registered output handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r         <= '0;
            b_r         <= '0;
            row_r       <= '0;
            for (int j = 0; j < M; j++) acc_r[j] <= '0;
            result_r    <= '0;
            sat_r       <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r        <= bus.vectorA_bus;
                        b_r        <= bus.vectorB_bus;
                        row_r      <= '0;
                        in_ready_r <= 1'b0;
                        // Accumulation mode keeps the previous sums.
                        if (!bus.in_accum) begin
                            for (int j = 0; j < M; j++) acc_r[j] <= '0;
                        end
                    end
                end
                RUN: begin
                    for (int j = 0; j < M; j++) acc_r[j] <= acc_next_s[j];
                    row_r <= row_r + CW'(1);
                    if (last_row_s) begin
                        result_r    <= result_next_s;
                        sat_r       <= sat_next_s;
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        result_r    <= '0;
                        sat_r       <= 1'b0;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

endmodule
